cordic_iter_seq: RTL

- Sequencer for the CORDIC rotator. It drives the iteration counter (the counter's start/enable inputs) and reads its count back.
- It gates the CORDIC datapath: operand load, per-iteration step enable, result valid.
- It accepts operands and returns results over valid/ready handshakes.
- It sits between the filter front end and the CORDIC datapath, with the iteration counter and arctangent ROM alongside.

---
 rtl/cordic_iter_seq.sv | 109 ++++++++++
 1 files changed

// File: rtl/cordic_iter_seq.sv
// Sequencer for the CORDIC rotator: runs NITER micro-rotations per operand and cross-checks the external iteration counter.
// Optional back-to-back DONE->LOAD hand-over is enabled by defining CORDIC_SEQ_B2B_EN.
module cordic_iter_seq #(
   parameter int CNT_W = 6,
   parameter int NITER = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             ld_operand,
   output logic             iter_en,
   output logic             cnt_start,
   output logic             cnt_enable,
   input  logic [CNT_W-1:0] cnt_count,
   output logic             busy,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NITER - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic             err_q, err_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shadow_d   = shadow_q;
      err_d      = err_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      ld_operand = 1'b0;
      iter_en    = 1'b0;
      cnt_start  = 1'b0;
      cnt_enable = 1'b0;
      busy       = 1'b0;

      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            ld_operand = 1'b1;
            cnt_start  = 1'b1;
            cnt_enable = 1'b1;
            busy       = 1'b1;
            shadow_d   = '0;
            state_d    = ITER;
         end
         ITER: begin
            iter_en    = 1'b1;
            cnt_enable = 1'b1;
            busy       = 1'b1;
            shadow_d   = shadow_q + 1'b1;
            // The shadow only flags disagreement; termination trusts the real counter.
            if (cnt_count != shadow_q) begin
               err_d = 1'b1;
            end
            if (cnt_count == LAST_CNT) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
`ifdef CORDIC_SEQ_B2B_EN
            in_ready = out_ready;
            if (out_ready) begin
               state_d = in_valid ? LOAD : IDLE;
            end
`else
            if (out_ready) begin
               state_d = IDLE;
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign err = err_q;

endmodule
